// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch display path: scan-slot encodings and
// active-low gfedcba glyphs for a common-anode 7-segment digit.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    S_D0 = 2'd0,
    S_D1 = 2'd1,
    S_D2 = 2'd2,
    S_D3 = 2'd3
  } scan_state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;

  // Next slot in the fixed D0 -> D1 -> D2 -> D3 -> D0 rotation.
  function automatic scan_state_e next_slot(input scan_state_e s);
    case (s)
      S_D0:    next_slot = S_D1;
      S_D1:    next_slot = S_D2;
      S_D2:    next_slot = S_D3;
      default: next_slot = S_D0;
    endcase
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD value -> active-low gfedcba glyph. Values 10-15 blank.
module seg7_decode
  import stopwatch_pkg::*;
(
  input  logic [3:0] val_i,
  output logic [6:0] seg_o
);

  // Glyph lookup; anything outside 0-9 lights nothing.
  always_comb begin
    seg_o = SEG_BLANK;
    case (val_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan.sv
// Four-digit mm:ss scanner for a common-anode 7-segment display.
// One digit is lit per refresh slot; all digits are snapshotted once per frame
// (on the D3 -> D0 tick) so a frame never mixes old and new values. In adjust
// mode the selected digit pair blinks.
// Optional build macro LEADING_ZERO_BLANK_EN: darken the minutes-tens digit
// whenever its snapshot value is zero.
module seven_seg_scan
  import stopwatch_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_HALF  = 125
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] dig0,
  input  logic [2:0] dig1,
  input  logic [3:0] dig2,
  input  logic [2:0] dig3,
  input  logic       adj_en,
  input  logic       adj_sel,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an
);

  localparam int RCNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BCNT_W = (BLINK_HALF  > 1) ? $clog2(BLINK_HALF)  : 1;
  localparam logic [RCNT_W-1:0] RCNT_LAST = RCNT_W'(REFRESH_DIV - 1);
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(BLINK_HALF - 1);

  logic [RCNT_W-1:0] rcnt_q, rcnt_d;
  logic              tick;

  scan_state_e       state_q, state_d;

  logic [3:0]        snap0_q, snap0_d;
  logic [2:0]        snap1_q, snap1_d;
  logic [3:0]        snap2_q, snap2_d;
  logic [2:0]        snap3_q, snap3_d;

  logic [BCNT_W-1:0] bcnt_q, bcnt_d;
  logic              phase_q, phase_d;

  logic [3:0]        cur_val;
  logic [6:0]        glyph;

  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;
  logic [3:0]        an_q, an_d;

  // Refresh prescaler: one tick per digit slot.
  always_comb begin
    tick   = (rcnt_q == RCNT_LAST);
    rcnt_d = tick ? '0 : rcnt_q + 1'b1;
  end

  // Scan FSM next state; the frame snapshot rides along with the D3 -> D0 move.
  always_comb begin
    state_d = state_q;
    snap0_d = snap0_q;
    snap1_d = snap1_q;
    snap2_d = snap2_q;
    snap3_d = snap3_q;
    if (tick) begin
      state_d = next_slot(state_q);
      if (state_q == S_D3) begin
        snap0_d = dig0;
        snap1_d = dig1;
        snap2_d = dig2;
        snap3_d = dig3;
      end
    end
  end

  // Blink timer: frozen at zero outside adjust mode, counts slot ticks inside it.
  always_comb begin
    bcnt_d  = bcnt_q;
    phase_d = phase_q;
    if (!adj_en) begin
      bcnt_d  = '0;
      phase_d = 1'b0;
    end else if (tick) begin
      if (bcnt_q == BCNT_LAST) begin
        bcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        bcnt_d  = bcnt_q + 1'b1;
      end
    end
  end

  // Pick the snapshot digit for the active slot.
  always_comb begin
    cur_val = snap0_q;
    case (state_q)
      S_D0:    cur_val = snap0_q;
      S_D1:    cur_val = {1'b0, snap1_q};
      S_D2:    cur_val = snap2_q;
      default: cur_val = {1'b0, snap3_q};
    endcase
  end

  seg7_decode u_decode (
    .val_i (cur_val),
    .seg_o (glyph)
  );

  // Next output values: one anode low per slot, then blink masking and
  // optional leading-zero blanking force anodes high. adj_en is used live so
  // leaving adjust mode shows the display on the very next cycle.
  always_comb begin
    seg_d = glyph;
    dp_d  = (state_q != S_D2);
    an_d  = 4'b1110;
    case (state_q)
      S_D0:    an_d = 4'b1110;
      S_D1:    an_d = 4'b1101;
      S_D2:    an_d = 4'b1011;
      default: an_d = 4'b0111;
    endcase
    if (adj_en && phase_q) begin
      if (adj_sel) an_d[3:2] = 2'b11;
      else         an_d[1:0] = 2'b11;
    end
`ifdef LEADING_ZERO_BLANK_EN
    if (snap3_q == 3'd0) an_d[3] = 1'b1;
`else
    an_d = an_d;
`endif
  end

  // State, snapshot, blink and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rcnt_q  <= '0;
      state_q <= S_D0;
      snap0_q <= '0;
      snap1_q <= '0;
      snap2_q <= '0;
      snap3_q <= '0;
      bcnt_q  <= '0;
      phase_q <= 1'b0;
      seg_q   <= SEG_BLANK;
      dp_q    <= 1'b1;
      an_q    <= 4'b1111;
    end else begin
      rcnt_q  <= rcnt_d;
      state_q <= state_d;
      snap0_q <= snap0_d;
      snap1_q <= snap1_d;
      snap2_q <= snap2_d;
      snap3_q <= snap3_d;
      bcnt_q  <= bcnt_d;
      phase_q <= phase_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      an_q    <= an_d;
    end
  end

  assign seg = seg_q;
  assign dp  = dp_q;
  assign an  = an_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed bench for seven_seg_scan with REFRESH_DIV=4, BLINK_HALF=2.
// Edge numbers E<n> in comments count rising edges since the latest reset release.
module tb_seven_seg_scan;

  logic       clk;
  logic       rst_n;
  logic [3:0] dig0;
  logic [2:0] dig1;
  logic [3:0] dig2;
  logic [2:0] dig3;
  logic       adj_en;
  logic       adj_sel;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;

  int vectors;
  int miscompares;

  seven_seg_scan #(
    .REFRESH_DIV (4),
    .BLINK_HALF  (2)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .dig0    (dig0),
    .dig1    (dig1),
    .dig2    (dig2),
    .dig3    (dig3),
    .adj_en  (adj_en),
    .adj_sel (adj_sel),
    .seg     (seg),
    .dp      (dp),
    .an      (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clocks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] an_e,
                     input logic [6:0] seg_e, input logic dp_e);
    vectors++;
    assert (an === an_e) else begin
      miscompares++;
      $error("FAIL %s an: observed %b expected %b", tag, an, an_e);
    end
    vectors++;
    assert (seg === seg_e) else begin
      miscompares++;
      $error("FAIL %s seg: observed %h expected %h", tag, seg, seg_e);
    end
    vectors++;
    assert (dp === dp_e) else begin
      miscompares++;
      $error("FAIL %s dp: observed %b expected %b", tag, dp, dp_e);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n   = 1'b0;
    dig0    = 4'd0;
    dig1    = 3'd0;
    dig2    = 4'd0;
    dig3    = 3'd0;
    adj_en  = 1'b0;
    adj_sel = 1'b0;

    // Power-on reset
    clocks(2);
    chk("por", 4'b1111, 7'h7F, 1'b1);
    rst_n = 1'b1;
    clocks(1);                       // E1
    chk("release_first", 4'b1110, 7'h40, 1'b1);
    clocks(5);                       // E6, slot 1
    chk("slot1_zero", 4'b1101, 7'h40, 1'b1);

    // Asynchronous reset mid-frame, no clock edge needed
    rst_n = 1'b0;
    #1;
    chk("async_rst", 4'b1111, 7'h7F, 1'b1);
    clocks(1);
    chk("rst_hold", 4'b1111, 7'h7F, 1'b1);

    // Scan 3,5,9,5 ; first frame still shows reset snapshot
    dig3 = 3'd3; dig2 = 4'd9; dig1 = 3'd5; dig0 = 4'd5;
    rst_n = 1'b1;
    clocks(1);                       // E1
    chk("rerelease", 4'b1110, 7'h40, 1'b1);
    clocks(15);                      // E16
    chk("frame1_slot3", 4'b0111, 7'h40, 1'b1);
    clocks(1);                       // E17
    chk("f2_slot0", 4'b1110, 7'h12, 1'b1);
    dig0 = 4'd7;                     // mid-frame change must not tear
    clocks(3);                       // E20
    chk("f2_slot0_hold", 4'b1110, 7'h12, 1'b1);
    clocks(1);                       // E21
    chk("f2_slot1", 4'b1101, 7'h12, 1'b1);
    clocks(4);                       // E25
    chk("f2_slot2", 4'b1011, 7'h10, 1'b0);
    clocks(3);                       // E28
    chk("f2_slot2_end", 4'b1011, 7'h10, 1'b0);
    clocks(1);                       // E29
    chk("f2_slot3", 4'b0111, 7'h30, 1'b1);
    clocks(3);                       // E32
    chk("f2_slot3_end", 4'b0111, 7'h30, 1'b1);
    clocks(1);                       // E33
    chk("f3_slot0_new", 4'b1110, 7'h78, 1'b1);

    // Out-of-range digit blanks segments, anode still driven
    dig0 = 4'hC;
    clocks(16);                      // E49
    chk("blank_val", 4'b1110, 7'h7F, 1'b1);

    // Tens digits 7 and 0
    dig1 = 3'd7;
    dig3 = 3'd0;
    clocks(20);                      // E69, slot 1 of frame 5
    chk("tens_7", 4'b1101, 7'h78, 1'b1);
    clocks(8);                       // E77, slot 3
`ifdef LEADING_ZERO_BLANK_EN
    chk("lead_zero", 4'b1111, 7'h40, 1'b1);
`else
    chk("lead_zero", 4'b0111, 7'h40, 1'b1);
`endif

    // Blink minutes pair; phase goes 1 at E84, back to 0 at E92
    adj_en  = 1'b1;
    adj_sel = 1'b1;
    clocks(4);                       // E81, phase 0
    chk("blink_p0_slot0", 4'b1110, 7'h7F, 1'b1);
    clocks(4);                       // E85, phase 1, slot 1 unaffected
    chk("blink_p1_slot1", 4'b1101, 7'h78, 1'b1);
    clocks(4);                       // E89, phase 1, slot 2 masked
    chk("blink_p1_slot2", 4'b1111, 7'h10, 1'b0);
    adj_sel = 1'b0;
    clocks(1);                       // E90, seconds pair selected instead
    chk("blink_sel_sec", 4'b1011, 7'h10, 1'b0);
    adj_sel = 1'b1;
    clocks(1);                       // E91
    chk("blink_sel_min", 4'b1111, 7'h10, 1'b0);
    adj_en = 1'b0;
    clocks(1);                       // E92, visible immediately
    chk("adj_off", 4'b1011, 7'h10, 1'b0);

    // Re-enter adjust: blink timer restarted from zero, phase 0 for two ticks
    adj_en = 1'b1;
    clocks(2);                       // E94, slot 3, phase 0
`ifdef LEADING_ZERO_BLANK_EN
    chk("readj_p0", 4'b1111, 7'h40, 1'b1);
`else
    chk("readj_p0", 4'b0111, 7'h40, 1'b1);
`endif
    adj_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
